// File: rtl/cfg_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_link_pkg
// Description : Definitions shared by the ground/DAQ configuration link
//               decoder. It holds the frame-parser state encoding, the
//               default header bytes, the frame length, and the address map
//               of the trigger configuration register bank. The highest
//               writable address is derived from that map.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_link_pkg;

    // Frame parser states. The encoding is fixed so that waveforms stay
    // readable across builds.
    typedef enum logic [2:0] {
        S_HUNT_H1  = 3'd0,
        S_HUNT_H2  = 3'd1,
        S_GET_ADDR = 3'd2,
        S_GET_DHI  = 3'd3,
        S_GET_DLO  = 3'd4,
        S_GET_CSUM = 3'd5
    } frame_state_t;

    // Frame layout: HDR0, HDR1, ADDR, DATA_HI, DATA_LO, CSUM
    localparam logic [7:0] c_hdr0_default = 8'hEB;
    localparam logic [7:0] c_hdr1_default = 8'h90;
    localparam int         c_frame_len    = 6;

    // Trigger configuration register bank address map
    localparam logic [7:0] c_addr_ctrl           = 8'h00;
    localparam logic [7:0] c_addr_cmd            = 8'h01;
    localparam logic [7:0] c_addr_status_clr     = 8'h02;
    localparam logic [7:0] c_addr_trg_mask_lo    = 8'h03;
    localparam logic [7:0] c_addr_trg_mask_hi    = 8'h04;
    localparam logic [7:0] c_addr_trg_polarity   = 8'h05;
    localparam logic [7:0] c_addr_trg_thresh_0   = 8'h06;
    localparam logic [7:0] c_addr_trg_thresh_1   = 8'h07;
    localparam logic [7:0] c_addr_trg_thresh_2   = 8'h08;
    localparam logic [7:0] c_addr_trg_thresh_3   = 8'h09;
    localparam logic [7:0] c_addr_coinc_window   = 8'h0A;
    localparam logic [7:0] c_addr_coinc_majority = 8'h0B;
    localparam logic [7:0] c_addr_prescale_0     = 8'h0C;
    localparam logic [7:0] c_addr_prescale_1     = 8'h0D;
    localparam logic [7:0] c_addr_holdoff        = 8'h0E;
    localparam logic [7:0] c_addr_veto_width     = 8'h0F;
    localparam logic [7:0] c_addr_readout_window = 8'h10;
    localparam logic [7:0] c_addr_pretrig_depth  = 8'h11;
    localparam logic [7:0] c_addr_ext_trg_ctrl   = 8'h12;
    localparam logic [7:0] c_addr_ext_trg_delay  = 8'h13;

    // The last register in the bank is the highest writable address.
    localparam logic [7:0] c_max_addr = c_addr_ext_trg_delay;

    // Frame checksum: the modulo-256 sum of the three payload bytes.
    function automatic logic [7:0] csum8(
        input logic [7:0] addr,
        input logic [7:0] dhi,
        input logic [7:0] dlo
    );
        logic [7:0] sum;
        sum = addr + dhi;
        sum = sum + dlo;
        return sum;
    endfunction

endpackage : cfg_link_pkg
`default_nettype wire

// File: rtl/cfg_frame_decoder_sat_cnt8.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt8
// Description : 8-bit event counter. It holds at 8'hFF instead of wrapping
//               and has a synchronous clear. Clear takes priority over
//               increment.
// Ports       : clk_in   - clock
//               rst_in_N - asynchronous active-low reset (count -> 0)
//               clr      - synchronous clear
//               inc      - count one event this cycle
//               count    - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt8 (
    input  logic       clk_in,
    input  logic       rst_in_N,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] r_count;

    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            r_count <= 8'h00;
        end else if (clr) begin
            r_count <= 8'h00;
        end else if (inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign count = r_count;

endmodule : sat_cnt8
`default_nettype wire

// File: rtl/cfg_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cfg_frame_decoder
// Description : Parses the byte stream from the serial link receiver into
//               write transactions for the trigger configuration register
//               bank. The frame format is
//               HDR0 HDR1 ADDR DATA_HI DATA_LO CSUM, where
//               CSUM = (ADDR + DATA_HI + DATA_LO) mod 256. A frame is dropped
//               and counted if its checksum is wrong, if its address is out
//               of range, or if it stalls between bytes.
// Ports       : clk_in           - system clock (50 MHz)
//               rst_in_N         - asynchronous active-low reset
//               rx_data_in       - received byte
//               rx_valid_in      - one-cycle strobe qualifying rx_data_in
//               wr_out           - one-cycle register-bank write strobe
//               wr_addr_out      - write address, held until next good frame
//               data_out         - write data {DATA_HI, DATA_LO}, held
//               csum_err_cnt_out - saturating checksum-failure count
//               addr_err_cnt_out - saturating out-of-range-address count
//               timeout_cnt_out  - saturating intra-frame timeout count
//               frame_busy_out   - parser is somewhere inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_frame_decoder
    import cfg_link_pkg::*;
#(
    parameter logic [7:0]  HDR0           = c_hdr0_default,
    parameter logic [7:0]  HDR1           = c_hdr1_default,
    parameter logic [7:0]  MAX_ADDR       = c_max_addr,
    // Maximum idle clocks between bytes inside a frame; must be >= 2
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk_in,
    input  logic        rst_in_N,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        wr_out,
    output logic [7:0]  wr_addr_out,
    output logic [15:0] data_out,
    output logic [7:0]  csum_err_cnt_out,
    output logic [7:0]  addr_err_cnt_out,
    output logic [7:0]  timeout_cnt_out,
    output logic        frame_busy_out
);

    // The idle counter only has to reach TIMEOUT_CYCLES-1.
    localparam int               TO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

    frame_state_t     r_state;
    frame_state_t     w_state_next;

    logic [7:0]       r_addr;
    logic [7:0]       r_dhi;
    logic [7:0]       r_dlo;
    logic [TO_W-1:0]  r_to_cnt;

    logic             r_wr;
    logic [7:0]       r_wr_addr;
    logic [15:0]      r_wr_data;

    logic [7:0]       w_sum;
    logic             w_write;
    logic             w_csum_err;
    logic             w_addr_err;
    logic             w_timeout;

    assign w_sum = csum8(r_addr, r_dhi, r_dlo);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            r_state <= S_HUNT_H1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and frame outcome decode. A byte strobe always takes
    // precedence over the timeout, so a byte that arrives on the last
    // allowed idle cycle still counts as part of the frame.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_csum_err   = 1'b0;
        w_addr_err   = 1'b0;
        w_timeout    = 1'b0;

        if (rx_valid_in) begin
            case (r_state)
                S_HUNT_H1: begin
                    if (rx_data_in == HDR0) begin
                        w_state_next = S_HUNT_H2;
                    end
                end
                S_HUNT_H2: begin
                    if (rx_data_in == HDR1) begin
                        w_state_next = S_GET_ADDR;
                    end else if (rx_data_in == HDR0) begin
                        // A repeated HDR0 may be the real start of a frame.
                        w_state_next = S_HUNT_H2;
                    end else begin
                        w_state_next = S_HUNT_H1;
                    end
                end
                S_GET_ADDR: w_state_next = S_GET_DHI;
                S_GET_DHI:  w_state_next = S_GET_DLO;
                S_GET_DLO:  w_state_next = S_GET_CSUM;
                S_GET_CSUM: begin
                    w_state_next = S_HUNT_H1;
                    if (w_sum != rx_data_in) begin
                        w_csum_err = 1'b1;
                    end else if (r_addr > MAX_ADDR) begin
                        w_addr_err = 1'b1;
                    end else begin
                        w_write = 1'b1;
                    end
                end
                default: w_state_next = S_HUNT_H1;
            endcase
        end else if ((r_state != S_HUNT_H1) && (r_to_cnt == c_to_last)) begin
            w_state_next = S_HUNT_H1;
            w_timeout    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Payload byte latches. Header values arriving here are plain data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            r_addr <= 8'h00;
            r_dhi  <= 8'h00;
            r_dlo  <= 8'h00;
        end else if (rx_valid_in) begin
            case (r_state)
                S_GET_ADDR: r_addr <= rx_data_in;
                S_GET_DHI:  r_dhi  <= rx_data_in;
                S_GET_DLO:  r_dlo  <= rx_data_in;
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte idle counter. It is idle while hunting for HDR0 and
    // restarts on every received byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            r_to_cnt <= '0;
        end else if (rx_valid_in || (r_state == S_HUNT_H1) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Write port. Address and data move only on an accepted frame, so
    // dropped frames never disturb the values last presented to the bank.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            r_wr      <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 16'h0000;
        end else begin
            r_wr <= w_write;
            if (w_write) begin
                r_wr_addr <= r_addr;
                r_wr_data <= {r_dhi, r_dlo};
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counters. They clear only on reset.
    // ------------------------------------------------------------------
    sat_cnt8 u_csum_err_cnt (
        .clk_in   (clk_in),
        .rst_in_N (rst_in_N),
        .clr      (1'b0),
        .inc      (w_csum_err),
        .count    (csum_err_cnt_out)
    );

    sat_cnt8 u_addr_err_cnt (
        .clk_in   (clk_in),
        .rst_in_N (rst_in_N),
        .clr      (1'b0),
        .inc      (w_addr_err),
        .count    (addr_err_cnt_out)
    );

    sat_cnt8 u_timeout_cnt (
        .clk_in   (clk_in),
        .rst_in_N (rst_in_N),
        .clr      (1'b0),
        .inc      (w_timeout),
        .count    (timeout_cnt_out)
    );

    assign wr_out         = r_wr;
    assign wr_addr_out    = r_wr_addr;
    assign data_out       = r_wr_data;
    assign frame_busy_out = (r_state != S_HUNT_H1);

endmodule : cfg_frame_decoder
`default_nettype wire

// File: tb/tb_cfg_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_frame_decoder
// Description : Self-checking bench for cfg_frame_decoder. It applies
//               directed byte streams. A frame-level reference model
//               predicts every output on every clock, and hand-computed
//               literals pin the expected values after each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_frame_decoder;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr;
    logic [7:0]  wr_addr;
    logic [15:0] wdata;
    logic [7:0]  csum_cnt;
    logic [7:0]  addr_cnt;
    logic [7:0]  to_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int wr_pulses = 0;

    cfg_frame_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in           (clk),
        .rst_in_N         (rst_n),
        .rx_data_in       (rx_data),
        .rx_valid_in      (rx_valid),
        .wr_out           (wr),
        .wr_addr_out      (wr_addr),
        .data_out         (wdata),
        .csum_err_cnt_out (csum_cnt),
        .addr_err_cnt_out (addr_cnt),
        .timeout_cnt_out  (to_cnt),
        .frame_busy_out   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // pos: number of frame bytes accepted so far (0 = hunting for HDR0)
    int   pos    = 0;
    int   idle   = 0;
    int   fa     = 0;
    int   fh     = 0;
    int   fl     = 0;
    bit   m_wr   = 0;
    int   m_addr = 0;
    int   m_data = 0;
    int   m_csum = 0;
    int   m_aerr = 0;
    int   m_to   = 0;

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0; idle = 0; fa = 0; fh = 0; fl = 0;
            m_wr = 0; m_addr = 0; m_data = 0;
            m_csum = 0; m_aerr = 0; m_to = 0;
        end else begin
            m_wr = 0;
            if (rx_valid) begin
                int b;
                b = int'(rx_data);
                idle = 0;
                if (pos == 0) begin
                    if (b == 'hEB) pos = 1;
                end else if (pos == 1) begin
                    if (b == 'h90)      pos = 2;
                    else if (b == 'hEB) pos = 1;
                    else                pos = 0;
                end else if (pos == 2) begin
                    fa = b; pos = 3;
                end else if (pos == 3) begin
                    fh = b; pos = 4;
                end else if (pos == 4) begin
                    fl = b; pos = 5;
                end else begin
                    pos = 0;
                    if (((fa + fh + fl) % 256) != b) m_csum = sat(m_csum);
                    else if (fa > 'h13)              m_aerr = sat(m_aerr);
                    else begin
                        m_wr = 1; m_addr = fa; m_data = fh * 256 + fl;
                    end
                end
            end else if (pos != 0) begin
                if (idle == TO - 1) begin
                    pos = 0; idle = 0; m_to = sat(m_to);
                end else begin
                    idle++;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        check("wr_out",       32'(wr),       32'(m_wr));
        check("wr_addr_out",  32'(wr_addr),  m_addr);
        check("data_out",     32'(wdata),    m_data);
        check("csum_err_cnt", 32'(csum_cnt), m_csum);
        check("addr_err_cnt", 32'(addr_cnt), m_aerr);
        check("timeout_cnt",  32'(to_cnt),   m_to);
        check("frame_busy",   32'(busy),     32'(pos != 0));
        if (wr === 1'b1) wr_pulses++;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic strobe(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] h,
                         input logic [7:0] l, input logic [7:0] c);
        strobe(8'hEB); strobe(8'h90); strobe(a); strobe(h); strobe(l); strobe(c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle_cycles(3);
        check("reset_wr",   32'(wr),    0);
        check("reset_busy", 32'(busy),  0);
        check("reset_data", 32'(wdata), 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // 1: good frame, one strobe every 4 clocks
        p0 = wr_pulses;
        begin
            logic [7:0] seq [6];
            seq = '{8'hEB, 8'h90, 8'h00, 8'h00, 8'h01, 8'h01};
            for (int i = 0; i < 6; i++) begin
                strobe(seq[i]);
                if (i == 5) begin
                    check("t1_wr_latency", 32'(wr), 1);
                    idle_cycles(1);
                    check("t1_wr_one_cycle", 32'(wr), 0);
                    idle_cycles(2);
                end else begin
                    idle_cycles(3);
                end
            end
        end
        check("t1_pulses", wr_pulses - p0, 1);
        check("t1_addr",   32'(wr_addr), 32'h00);
        check("t1_data",   32'(wdata),   32'h0001);
        check("t1_csum",   32'(csum_cnt), 0);

        // 2: bad checksum, then the corrected frame
        p0 = wr_pulses;
        frame(8'h01, 8'h00, 8'h60, 8'h62);
        idle_cycles(2);
        check("t2_bad_pulses", wr_pulses - p0, 0);
        check("t2_csum_cnt",   32'(csum_cnt), 1);
        check("t2_addr_held",  32'(wr_addr), 32'h00);
        check("t2_data_held",  32'(wdata),   32'h0001);
        frame(8'h01, 8'h00, 8'h60, 8'h61);
        idle_cycles(2);
        check("t2_good_pulses", wr_pulses - p0, 1);
        check("t2_addr", 32'(wr_addr), 32'h01);
        check("t2_data", 32'(wdata),   32'h0060);

        // 3: address above MAX_ADDR with a valid checksum
        p0 = wr_pulses;
        frame(8'h14, 8'h12, 8'h34, 8'h5A);
        idle_cycles(2);
        check("t3_pulses",   wr_pulses - p0, 0);
        check("t3_addr_cnt", 32'(addr_cnt), 1);
        check("t3_addr_held", 32'(wr_addr), 32'h01);

        // 4: header resync
        p0 = wr_pulses;
        begin
            logic [7:0] s4 [8];
            s4 = '{8'h00, 8'hEB, 8'hEB, 8'h90, 8'h0E, 8'h00, 8'hC8, 8'hD6};
            foreach (s4[i]) strobe(s4[i]);
        end
        idle_cycles(2);
        check("t4a_pulses", wr_pulses - p0, 1);
        check("t4a_addr", 32'(wr_addr), 32'h0E);
        check("t4a_data", 32'(wdata),   32'h00C8);
        p0 = wr_pulses;
        begin
            logic [7:0] s5 [7];
            s5 = '{8'hEB, 8'h00, 8'h90, 8'h0E, 8'h00, 8'hC8, 8'hD6};
            foreach (s5[i]) strobe(s5[i]);
        end
        idle_cycles(2);
        check("t4b_pulses", wr_pulses - p0, 0);
        check("t4b_busy",   32'(busy), 0);
        check("t4b_csum",   32'(csum_cnt), 1);

        // 5: timeout after 16 idle clocks, then a good frame
        strobe(8'hEB); strobe(8'h90); strobe(8'h05);
        idle_cycles(15);
        check("t5_busy_before", 32'(busy), 1);
        idle_cycles(1);
        check("t5_timeout_cnt", 32'(to_cnt), 1);
        check("t5_busy_after",  32'(busy), 0);
        p0 = wr_pulses;
        frame(8'h05, 8'h12, 8'h34, 8'h4B);
        idle_cycles(2);
        check("t5_pulses", wr_pulses - p0, 1);
        check("t5_addr", 32'(wr_addr), 32'h05);
        check("t5_data", 32'(wdata),   32'h1234);
        // byte arriving on the 16th idle cycle wins over the timeout
        p0 = wr_pulses;
        strobe(8'hEB); strobe(8'h90); strobe(8'h07);
        idle_cycles(15);
        strobe(8'hAA); strobe(8'h55); strobe(8'h06);
        idle_cycles(2);
        check("t5b_timeout_cnt", 32'(to_cnt), 1);
        check("t5b_pulses", wr_pulses - p0, 1);
        check("t5b_data", 32'(wdata), 32'hAA55);

        // 6: saturation of the checksum error counter
        for (int i = 0; i < 300; i++) frame(8'h00, 8'h00, 8'h00, 8'h01);
        idle_cycles(2);
        check("t6_csum_sat", 32'(csum_cnt), 32'hFF);

        // 7: reset in the middle of a frame
        strobe(8'hEB); strobe(8'h90); strobe(8'h03); strobe(8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("t7_wr",   32'(wr),       0);
        check("t7_busy", 32'(busy),     0);
        check("t7_csum", 32'(csum_cnt), 0);
        check("t7_addr_cnt", 32'(addr_cnt), 0);
        check("t7_to",   32'(to_cnt),   0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);

        // 8: frames after release; the top address, then a back-to-back
        //    frame whose checksum wraps through 0x200
        p0 = wr_pulses;
        frame(8'h13, 8'hAB, 8'hCD, 8'h8B);
        check("t8_addr", 32'(wr_addr), 32'h13);
        check("t8_data", 32'(wdata),   32'hABCD);
        frame(8'h02, 8'hFF, 8'hFF, 8'h00);
        idle_cycles(2);
        check("t8_pulses", wr_pulses - p0, 2);
        check("t8_addr2",  32'(wr_addr), 32'h02);
        check("t8_data2",  32'(wdata),   32'hFFFF);
        check("t8_csum",   32'(csum_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cfg_frame_decoder
`default_nettype wire
